// File: rtl/systolic_seq_ctrl_if.sv
// Handshake and sequencing bus between the TPU top level and the systolic sequencer.
// The sequencer connects through the slave modport, and its driver connects through master.
interface systolic_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned CYC_W  = 9,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned SET_W  = 2
);
    logic              tpu_start;
    logic [SET_W-1:0]  cfg_num_sets;
    logic              stall;
    logic              sram_write_enable;
    logic [ADDR_W-1:0] addr_serial_num;
    logic              alu_start;
    logic [CYC_W-1:0]  cycle_num;
    logic [IDX_W-1:0]  matrix_index;
    logic [SET_W-1:0]  data_set;
    logic              tpu_busy;
    logic              tpu_done;

    modport master (
        output tpu_start, cfg_num_sets, stall,
        input  sram_write_enable, addr_serial_num, alu_start, cycle_num,
               matrix_index, data_set, tpu_busy, tpu_done
    );

    modport slave (
        input  tpu_start, cfg_num_sets, stall,
        output sram_write_enable, addr_serial_num, alu_start, cycle_num,
               matrix_index, data_set, tpu_busy, tpu_done
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the systolic-array datapath: drives the read addresses, the shift enable and the output-SRAM writes.
// The run length is set at start time by the number of data sets, and a stall input freezes the whole sequence.
//
//   state | meaning
//   IDLE  | waiting for tpu_start; tpu_done pulses here once after a run
//   LOAD  | first input-SRAM read issued (addr 0 -> 1)
//   WAIT  | pipeline fill (addr 1 -> 2)
//   ROLL  | array shifting; write window opens at cycle_num >= ARRAY_SIZE+1
module systolic_seq_ctrl #(
    parameter int unsigned ARRAY_SIZE    = 8,
    parameter int unsigned K_ACCUM_DEPTH = 8,
    parameter int unsigned MAX_SETS      = 4,
    parameter int unsigned ADDR_W        = 7,
    parameter int unsigned CYC_W         = 9,
    parameter int unsigned IDX_W         = 6,
    parameter int unsigned SET_W         = 2
) (
    input  logic             clk,
    input  logic             srstn,
    systolic_seq_ctrl_if.slave io_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        ROLL = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] WIN_START = CYC_W'(ARRAY_SIZE + 1);
    localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(K_ACCUM_DEPTH - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(MAX_SETS - 1);

    state_t            r_state;
    logic [CYC_W-1:0]  r_cycle;
    logic [IDX_W-1:0]  r_midx;
    logic [SET_W-1:0]  r_set;
    logic [ADDR_W-1:0] r_addr;
    logic [SET_W-1:0]  r_num_sets;
    logic              r_done;

    logic              w_alu_start;
    logic              w_in_window;
    logic              w_write;
    logic [SET_W-1:0]  w_cfg_clamped;

    assign w_alu_start   = (r_state == ROLL) && !io_bus.stall;
    assign w_in_window   = (r_cycle >= WIN_START);
    assign w_write       = w_alu_start && w_in_window;
    assign w_cfg_clamped = (32'(io_bus.cfg_num_sets) >= MAX_SETS) ? SET_LAST
                                                                  : io_bus.cfg_num_sets;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state    <= IDLE;
            r_cycle    <= '0;
            r_midx     <= '0;
            r_set      <= '0;
            r_addr     <= '0;
            r_num_sets <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_cycle <= '0;
                    r_midx  <= '0;
                    r_set   <= '0;
                    if (io_bus.tpu_start) begin
                        r_state    <= LOAD;
                        r_addr     <= '0;
                        r_num_sets <= w_cfg_clamped;
                    end
                end
                LOAD: begin
                    r_done  <= 1'b0;
                    r_cycle <= '0;
                    r_midx  <= '0;
                    r_set   <= '0;
                    r_addr  <= ADDR_W'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_done  <= 1'b0;
                    r_cycle <= '0;
                    r_midx  <= '0;
                    r_set   <= '0;
                    r_addr  <= ADDR_W'(2);
                    r_state <= ROLL;
                end
                ROLL: begin
                    // A stalled cycle leaves every register untouched.
                    if (!io_bus.stall) begin
                        r_done <= 1'b0;
                        if (r_cycle != '1) r_cycle <= r_cycle + 1'b1;
                        if (r_addr != '1)  r_addr  <= r_addr + 1'b1;
                        if (w_in_window) begin
                            if (r_midx == K_LAST) begin
                                r_midx <= '0;
                                if (r_set == r_num_sets) begin
                                    r_state <= IDLE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_set <= r_set + 1'b1;
                                end
                            end else begin
                                r_midx <= r_midx + 1'b1;
                            end
                        end else begin
                            r_midx <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.alu_start         = w_alu_start;
    assign io_bus.sram_write_enable = w_write;
    assign io_bus.tpu_busy          = (r_state != IDLE);
    assign io_bus.tpu_done          = r_done;
    assign io_bus.addr_serial_num   = r_addr;
    assign io_bus.cycle_num         = r_cycle;
    assign io_bus.matrix_index      = r_midx;
    assign io_bus.data_set          = r_set;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: a default-sized instance with a 3-bit set field (so clamping is reachable)
// and a small 4x4 instance for the write-window boundary and address saturation.
module tb_systolic_seq_ctrl;

    logic clk = 1'b0;
    logic srstn;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.ADDR_W(7), .CYC_W(9), .IDX_W(6), .SET_W(3)) bus_a ();
    systolic_seq_ctrl_if #(.ADDR_W(3), .CYC_W(9), .IDX_W(6), .SET_W(2)) bus_b ();

    systolic_seq_ctrl #(
        .ARRAY_SIZE(8), .K_ACCUM_DEPTH(8), .MAX_SETS(4),
        .ADDR_W(7), .CYC_W(9), .IDX_W(6), .SET_W(3)
    ) u_dut_a (
        .clk(clk), .srstn(srstn), .io_bus(bus_a.slave)
    );

    systolic_seq_ctrl #(
        .ARRAY_SIZE(4), .K_ACCUM_DEPTH(2), .MAX_SETS(4),
        .ADDR_W(3), .CYC_W(9), .IDX_W(6), .SET_W(2)
    ) u_dut_b (
        .clk(clk), .srstn(srstn), .io_bus(bus_b.slave)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    // Starts a run on instance A from IDLE (called at a falling edge) and follows it to completion.
    task automatic run_a(input string nm, input int cfg, input int exp_writes, input int exp_edges,
                         input int exp_end_addr, input int stall_at, input int stall_len,
                         input int pulse_at, input bit restart);
        int edges, writes, stall_left, hold_cyc, hold_idx;
        bit stalled, pulsed;
        writes = 0; stall_left = 0; hold_cyc = 0; hold_idx = 0;
        stalled = 1'b0; pulsed = 1'b0;
        bus_a.cfg_num_sets = 3'(cfg);
        bus_a.tpu_start    = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus_a.tpu_start    = 1'b0;
        bus_a.cfg_num_sets = 3'd0;
        #1;
        chk({nm, "_load_busy"}, int'(bus_a.tpu_busy), 1);
        chk({nm, "_load_addr"}, int'(bus_a.addr_serial_num), 0);
        while (!bus_a.tpu_done && edges < 300) begin
            bus_a.tpu_start = 1'b0;
            if (!stalled && stall_at >= 0 && bus_a.alu_start && int'(bus_a.cycle_num) == stall_at) begin
                stalled    = 1'b1;
                stall_left = stall_len;
                hold_cyc   = int'(bus_a.cycle_num);
                hold_idx   = int'(bus_a.matrix_index);
                bus_a.stall = 1'b1;
            end
            if (!pulsed && pulse_at >= 0 && bus_a.alu_start && int'(bus_a.cycle_num) == pulse_at) begin
                pulsed = 1'b1;
                bus_a.tpu_start = 1'b1;
            end
            #1;
            if (stall_left > 0) begin
                chk({nm, "_stall_alu"}, int'(bus_a.alu_start), 0);
                chk({nm, "_stall_wen"}, int'(bus_a.sram_write_enable), 0);
                chk({nm, "_stall_cyc"}, int'(bus_a.cycle_num), hold_cyc);
                chk({nm, "_stall_idx"}, int'(bus_a.matrix_index), hold_idx);
                stall_left--;
            end else if (bus_a.sram_write_enable) begin
                if (writes == 0) begin
                    chk({nm, "_first_cyc"}, int'(bus_a.cycle_num), 9);
                    chk({nm, "_first_addr"}, int'(bus_a.addr_serial_num), 11);
                end
                chk({nm, "_idx"}, int'(bus_a.matrix_index), writes % 8);
                chk({nm, "_set"}, int'(bus_a.data_set), writes / 8);
                writes++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (stall_left == 0) bus_a.stall = 1'b0;
        end
        bus_a.tpu_start = 1'b0;
        chk({nm, "_done_seen"}, int'(bus_a.tpu_done), 1);
        chk({nm, "_done_edge"}, edges, exp_edges);
        chk({nm, "_writes"}, writes, exp_writes);
        chk({nm, "_done_busy"}, int'(bus_a.tpu_busy), 0);
        if (restart) begin
            bus_a.tpu_start    = 1'b1;
            bus_a.cfg_num_sets = 3'd0;
            @(posedge clk);
            @(negedge clk);
            bus_a.tpu_start = 1'b0;
            #1;
            chk({nm, "_re_busy"}, int'(bus_a.tpu_busy), 1);
            chk({nm, "_re_addr"}, int'(bus_a.addr_serial_num), 0);
            chk({nm, "_re_done"}, int'(bus_a.tpu_done), 0);
            edges = 0;
            while (!bus_a.tpu_done && edges < 100) begin
                @(posedge clk);
                @(negedge clk);
                edges++;
            end
            chk({nm, "_re_done_seen"}, int'(bus_a.tpu_done), 1);
            chk({nm, "_re_done_edge"}, edges, 19);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk({nm, "_done_pulse"}, int'(bus_a.tpu_done), 0);
        chk({nm, "_end_addr"}, int'(bus_a.addr_serial_num), exp_end_addr);
    endtask

    initial begin
        int  edges, writes;
        bit  seen;
        srstn = 1'b0;
        bus_a.tpu_start = 1'b0; bus_a.cfg_num_sets = 3'd0; bus_a.stall = 1'b0;
        bus_b.tpu_start = 1'b0; bus_b.cfg_num_sets = 2'd0; bus_b.stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        srstn = 1'b1;
        #1;
        chk("rst_busy", int'(bus_a.tpu_busy), 0);
        chk("rst_cyc",  int'(bus_a.cycle_num), 0);
        chk("rst_idx",  int'(bus_a.matrix_index), 0);
        chk("rst_set",  int'(bus_a.data_set), 0);
        chk("rst_addr", int'(bus_a.addr_serial_num), 0);
        chk("rst_done", int'(bus_a.tpu_done), 0);
        chk("rst_alu",  int'(bus_a.alu_start), 0);
        chk("rst_wen",  int'(bus_a.sram_write_enable), 0);
        chk("rst_b_busy", int'(bus_b.tpu_busy), 0);

        run_a("cfg2",   2, 24, 36, 35, -1, 0, -1, 1'b0);
        run_a("cfg0",   0,  8, 20, 19, -1, 0, -1, 1'b0);
        run_a("cfg3",   3, 32, 44, 43, -1, 0, -1, 1'b0);
        run_a("cfg7",   7, 32, 44, 43, -1, 0, -1, 1'b0);
        run_a("stall",  2, 24, 41, 35, 12, 5, -1, 1'b0);
        run_a("busy_start", 0, 8, 20, 19, -1, 0, 3, 1'b0);
        run_a("restart", 1, 16, 28, 19, -1, 0, -1, 1'b1);

        // Reset pulled in the middle of ROLL.
        bus_a.cfg_num_sets = 3'd2;
        bus_a.tpu_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.tpu_start = 1'b0;
        repeat (10) @(negedge clk);
        srstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        srstn = 1'b1;
        #1;
        chk("mrst_busy", int'(bus_a.tpu_busy), 0);
        chk("mrst_cyc",  int'(bus_a.cycle_num), 0);
        chk("mrst_idx",  int'(bus_a.matrix_index), 0);
        chk("mrst_set",  int'(bus_a.data_set), 0);
        chk("mrst_addr", int'(bus_a.addr_serial_num), 0);
        chk("mrst_alu",  int'(bus_a.alu_start), 0);
        chk("mrst_wen",  int'(bus_a.sram_write_enable), 0);
        seen = 1'b0;
        repeat (4) begin
            if (bus_a.tpu_done) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        chk("mrst_no_done", int'(seen), 0);
        run_a("post_rst", 2, 24, 36, 35, -1, 0, -1, 1'b0);

        // Small instance: window opens at cycle 5, address saturates at 7.
        bus_b.cfg_num_sets = 2'd1;
        bus_b.tpu_start    = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus_b.tpu_start = 1'b0;
        writes = 0;
        while (!bus_b.tpu_done && edges < 100) begin
            #1;
            if (bus_b.sram_write_enable) begin
                if (writes == 0) chk("b_first_cyc", int'(bus_b.cycle_num), 5);
                chk("b_idx", int'(bus_b.matrix_index), writes % 2);
                chk("b_set", int'(bus_b.data_set), writes / 2);
                writes++;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("b_done_seen", int'(bus_b.tpu_done), 1);
        chk("b_done_edge", edges, 12);
        chk("b_writes", writes, 4);
        chk("b_addr_sat", int'(bus_b.addr_serial_num), 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Parametrised sequencer for the systolic-array datapath. It generalises the fixed 8×8, three-data-set controller in four ways: the array size, accumulation depth and counter widths are parameters; the number of data sets is chosen at run time; a stall input freezes the sequence; and it reports busy and done status. It sits between the top-level TPU start/done handshake and the address selector, systolic array and output-SRAM write port. It drives the read-address serial number, the ALU shift enable, the cycle counter, the output matrix index, the data-set index and the output-SRAM write enable.

## Interface
Parameters:
- ARRAY_SIZE, 8, systolic array dimension (PEs per row/column), ≥2
- K_ACCUM_DEPTH, 8, output rows written per data set, ≥1
- MAX_SETS, 4, maximum data sets per run, ≥1
- ADDR_W, 7, width of addr_serial_num
- CYC_W, 9, width of cycle_num; must hold ARRAY_SIZE+1+K_ACCUM_DEPTH*MAX_SETS
- IDX_W, 6, width of matrix_index; must hold K_ACCUM_DEPTH-1
- SET_W, 2, width of data_set and cfg_num_sets; must hold MAX_SETS-1

Ports:
- clk  in  1  clock, all state on rising edge
- srstn  in  1  synchronous active-low reset
- tpu_start  in  1  run request, sampled only in IDLE
- cfg_num_sets  in  SET_W  data sets minus one (0 → 1 set), latched on accepted start; values ≥MAX_SETS clamp to MAX_SETS-1
- stall  in  1  upstream data not ready; freezes sequence while high
- sram_write_enable  out  1  output-SRAM write strobe
- addr_serial_num  out  ADDR_W  input-SRAM read address index
- alu_start  out  1  systolic shift/MAC enable
- cycle_num  out  CYC_W  ROLL-phase cycle counter
- matrix_index  out  IDX_W  output row being written
- data_set  out  SET_W  current data set
- tpu_busy  out  1  high in any state other than IDLE
- tpu_done  out  1  one-cycle completion pulse

## Operation
- Reset: state=IDLE, cycle_num=0, matrix_index=0, data_set=0, addr_serial_num=0, tpu_done=0, latched set count=0; all combinational outputs low.
- States:
  - IDLE: tpu_start → LOAD. On that edge addr_serial_num←0 and cfg_num_sets is latched (clamped). Otherwise addr_serial_num holds.
  - LOAD: → WAIT unconditionally, addr_serial_num←1.
  - WAIT: → ROLL unconditionally, addr_serial_num←2.
  - ROLL: runs until the final write, then → IDLE.
- Counters in IDLE, LOAD and WAIT: cycle_num, matrix_index and data_set are loaded with 0.
- ROLL, stall low:
  - cycle_num increments, saturating at all-ones.
  - addr_serial_num increments, saturating at 2^ADDR_W-1.
  - Write window is cycle_num ≥ ARRAY_SIZE+1. Inside the window, matrix_index increments; at K_ACCUM_DEPTH-1 it wraps to 0 and data_set increments.
  - Outside the window, matrix_index stays 0.
- ROLL, stall high: every register holds. alu_start=0 and sram_write_enable=0.
- Combinational outputs:
  - alu_start = (state==ROLL) & ~stall
  - sram_write_enable = alu_start & (cycle_num ≥ ARRAY_SIZE+1)
  - tpu_busy = (state≠IDLE)
- Completion: a write cycle with matrix_index==K_ACCUM_DEPTH-1 and data_set==latched count is the final write. On that edge the block goes to IDLE and tpu_done←1.
- tpu_done is high for exactly one cycle (in IDLE), then returns to 0.
- tpu_start while busy is ignored. A start in the same cycle as tpu_done is accepted.
- cfg_num_sets changes after the start is latched have no effect.
- Reset mid-run: the next cycle is IDLE with all reset values; no done pulse.

## Timing
- Start sampled at edge E0. State is LOAD after E0, WAIT after E1, ROLL after E2 (cycle_num=0, addr=2).
- First write cycle is the (ARRAY_SIZE+2)-th ROLL cycle (cycle_num=ARRAY_SIZE+1).
- Writes total K_ACCUM_DEPTH×(cfg+1), one per unstalled cycle.
- tpu_done is high the cycle after the final write. With no stall, the done cycle begins 3+ARRAY_SIZE+1+K×(cfg+1) edges after E0.
- Each stalled cycle adds exactly one cycle of latency. Outputs do not glitch: registered values only change on unstalled edges.

## Test plan
- Defaults, cfg=2, no stall:
  - First sram_write_enable when cycle_num=9, addr=11.
  - 24 writes with matrix_index sequence 0..7 ×3 and data_set 0,1,2.
  - tpu_done one cycle at edge 36 after start; addr frozen at 35 afterward.
- cfg=0: 8 writes, done at edge 20. cfg=3 → 32 writes. cfg=7 with MAX_SETS=4 → clamped to 32 writes.
- Stall high for 5 cycles at cycle_num=12 (matrix_index=3):
  - alu_start and write enable are low for those 5 cycles; all counters hold.
  - Done is delayed by exactly 5 cycles; the write count is unchanged.
- tpu_start pulsed during ROLL → no effect on counters or state. Start asserted on the tpu_done cycle → LOAD next cycle, addr=0.
- srstn low for 1 cycle mid-ROLL → all outputs at reset values; no tpu_done. A new start then produces a full normal run.
- ARRAY_SIZE=4, K_ACCUM_DEPTH=2, ADDR_W=3, cfg=1:
  - Writes start at cycle_num=5; 4 writes total.
  - addr_serial_num saturates at 7.
